// File: rtl/uart_rx_fifo_periph_if.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_periph_if
// Groups the CPU-side bus and serial line of the UART receive peripheral.
//   uart_in          serial RX line, idle high (master -> slave)
//   read_int         interrupt, high while FIFO not empty (slave -> master)
//   uart_to_cpu_buf  FIFO head entry, 0 when empty (slave -> master)
//   cpu_end_read     one-cycle pop strobe (master -> slave)
//   fifo_count       current FIFO occupancy (slave -> master)
//   overrun          sticky dropped-frame flag (slave -> master)
//   frame_err        sticky bad-stop-bit flag (slave -> master)
//   err_clr          clears both sticky flags (master -> slave)
//   leds_array       LED data from CPU (master -> slave)
//   write_leds       LED write strobe (master -> slave)
//   leds             registered LED outputs (slave -> master)
// -----------------------------------------------------------------------------
interface uart_rx_fifo_periph_if #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LED_WIDTH  = 8
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                  uart_in;
    logic                  read_int;
    logic [DATA_BITS-1:0]  uart_to_cpu_buf;
    logic                  cpu_end_read;
    logic [CNT_W-1:0]      fifo_count;
    logic                  overrun;
    logic                  frame_err;
    logic                  err_clr;
    logic [LED_WIDTH-1:0]  leds_array;
    logic                  write_leds;
    logic [LED_WIDTH-1:0]  leds;

    modport master (
        output uart_in, cpu_end_read, err_clr, leds_array, write_leds,
        input  read_int, uart_to_cpu_buf, fifo_count, overrun, frame_err, leds
    );

    modport slave (
        input  uart_in, cpu_end_read, err_clr, leds_array, write_leds,
        output read_int, uart_to_cpu_buf, fifo_count, overrun, frame_err, leds
    );
endinterface

// File: rtl/uart_rx_fifo_periph.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_periph
// UART receiver (8N1-style, configurable width) feeding a show-ahead FIFO,
// with a level interrupt, sticky overrun/framing flags and a CPU LED register.
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   uart_rx_fifo_periph_if.slave (serial line + CPU-side signals)
// -----------------------------------------------------------------------------
module uart_rx_fifo_periph #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned LED_WIDTH    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_rx_fifo_periph_if.slave   bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMR_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_t;

    logic [1:0]           r_sync;
    rx_state_t            r_state;
    logic [TMR_W-1:0]     r_tmr;
    logic [BIT_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_stop_wait;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_read_int;
    logic [DATA_BITS-1:0] r_head;
    logic                 r_overrun;
    logic                 r_frame_err;
    logic [LED_WIDTH-1:0] r_leds;

    logic                 w_line;
    logic                 w_tick;
    logic                 w_stop_smp;
    logic                 w_push;
    logic                 w_ferr_set;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_accept;
    logic                 w_ovr_set;
    logic [PTR_W-1:0]     w_rd_ptr_nxt;
    logic [CNT_W-1:0]     w_count_nxt;
    logic [DATA_BITS-1:0] w_head_nxt;

    assign w_line = r_sync[1];

    // Push/pop arbitration and next-state of the FIFO head view.
    always_comb begin
        w_tick       = (r_tmr == '0);
        w_stop_smp   = (r_state == S_STOP) && !r_stop_wait && w_tick;
        w_push       = w_stop_smp && w_line;
        w_ferr_set   = w_stop_smp && !w_line;
        w_pop        = bus.cpu_end_read && (r_count != '0);
        w_full       = (r_count == CNT_W'(FIFO_DEPTH));
        // A same-edge pop frees a slot, so a full FIFO still accepts the frame.
        w_accept     = w_push && (!w_full || w_pop);
        w_ovr_set    = w_push && w_full && !w_pop;
        w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_pop);
        w_count_nxt  = r_count + CNT_W'(w_accept) - CNT_W'(w_pop);
        w_head_nxt   = '0;
        if (w_count_nxt != '0) begin
            // Bypass when the entry being written becomes the new head.
            if (w_accept && (r_wr_ptr == w_rd_ptr_nxt)) w_head_nxt = r_shreg;
            else                                        w_head_nxt = r_mem[w_rd_ptr_nxt];
        end
    end

    // Line synchronizer and receive FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync      <= 2'b11;
            r_state     <= S_IDLE;
            r_tmr       <= '0;
            r_bit_idx   <= '0;
            r_shreg     <= '0;
            r_stop_wait <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], bus.uart_in};
            case (r_state)
                S_IDLE: begin
                    if (!w_line) begin
                        r_tmr   <= TMR_W'(CLKS_PER_BIT/2 - 1);
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (!w_line) begin
                            r_tmr     <= TMR_W'(CLKS_PER_BIT - 1);
                            r_bit_idx <= '0;
                            r_state   <= S_DATA;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_tmr <= r_tmr - 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_shreg <= {w_line, r_shreg[DATA_BITS-1:1]};
                        r_tmr   <= TMR_W'(CLKS_PER_BIT - 1);
                        if (r_bit_idx == BIT_W'(DATA_BITS - 1)) r_state <= S_STOP;
                        else                                   r_bit_idx <= r_bit_idx + 1'b1;
                    end else begin
                        r_tmr <= r_tmr - 1'b1;
                    end
                end
                S_STOP: begin
                    // After a bad stop bit, wait for an idle line before rearming.
                    if (r_stop_wait) begin
                        if (w_line) begin
                            r_stop_wait <= 1'b0;
                            r_state     <= S_IDLE;
                        end
                    end else if (w_tick) begin
                        if (w_line) r_state     <= S_IDLE;
                        else        r_stop_wait <= 1'b1;
                    end else begin
                        r_tmr <= r_tmr - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // FIFO storage; flushing is done through the pointers.
    always_ff @(posedge clk) begin
        if (w_accept) r_mem[r_wr_ptr] <= r_shreg;
    end

    // FIFO pointers, count, interrupt, sticky flags and LED register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_read_int  <= 1'b0;
            r_head      <= '0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_leds      <= '0;
        end else begin
            if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_count_nxt;
            r_read_int <= (w_count_nxt != '0);
            r_head     <= w_head_nxt;
            if (w_ovr_set)        r_overrun <= 1'b1;
            else if (bus.err_clr) r_overrun <= 1'b0;
            if (w_ferr_set)       r_frame_err <= 1'b1;
            else if (bus.err_clr) r_frame_err <= 1'b0;
            if (bus.write_leds)   r_leds <= bus.leds_array;
        end
    end

    assign bus.read_int        = r_read_int;
    assign bus.uart_to_cpu_buf = r_head;
    assign bus.fifo_count      = r_count;
    assign bus.overrun         = r_overrun;
    assign bus.frame_err       = r_frame_err;
    assign bus.leds            = r_leds;
endmodule

// File: tb/tb_uart_rx_fifo_periph.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo_periph
// Directed bench for uart_rx_fifo_periph: frames are bit-banged on uart_in,
// accepted bytes are queued in a scoreboard and compared on each CPU pop.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo_periph;
    localparam int unsigned CPB   = 16;
    localparam int unsigned DB    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LW    = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_fifo_periph_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .LED_WIDTH(LW)) bus ();

    uart_rx_fifo_periph #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .LED_WIDTH(LW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    bit         m_ovr  = 1'b0;
    bit         m_ferr = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, ".count"},    32'(bus.fifo_count), 32'(exp_q.size()));
        check({tag, ".read_int"}, 32'(bus.read_int),   32'(exp_q.size() != 0));
        check({tag, ".overrun"},  32'(bus.overrun),    32'(m_ovr));
        check({tag, ".frame_err"},32'(bus.frame_err),  32'(m_ferr));
    endtask

    // Drive one frame starting at a negedge. Stop sample lands on the
    // 155th posedge after the start bit is driven.
    task automatic send_frame(input logic [7:0] d, input bit stop,
                              input bit chk_lat, input bit pop_at_stop);
        logic [9:0] bits;
        logic [7:0] head;
        int         cyc;
        bits = {stop, d, 1'b0};
        cyc  = 0;
        for (int i = 0; i < 10; i++) begin
            bus.uart_in = bits[i];
            for (int c = 0; c < int'(CPB); c++) begin
                if (cyc == 154) begin
                    if (chk_lat) check("lat.before", 32'(bus.read_int), 32'd0);
                    if (pop_at_stop) begin
                        head = exp_q.pop_front();
                        check("popstop.head", 32'(bus.uart_to_cpu_buf), 32'(head));
                        bus.cpu_end_read = 1'b1;
                    end
                end
                if (cyc == 155) begin
                    bus.cpu_end_read = 1'b0;
                    if (chk_lat) begin
                        check("lat.after", 32'(bus.read_int), 32'd1);
                        check("lat.head",  32'(bus.uart_to_cpu_buf), 32'(d));
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        bus.uart_in = 1'b1;
        if (stop) begin
            if (exp_q.size() < int'(DEPTH)) exp_q.push_back(d);
            else                            m_ovr = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] head;
        head = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
        check({tag, ".buf"},   32'(bus.uart_to_cpu_buf), 32'(head));
        check({tag, ".count"}, 32'(bus.fifo_count),      32'(exp_q.size()));
        bus.cpu_end_read = 1'b1;
        @(negedge clk);
        bus.cpu_end_read = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic err_clear();
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        bus.uart_in      = 1'b1;
        bus.cpu_end_read = 1'b0;
        bus.err_clr      = 1'b0;
        bus.leds_array   = '0;
        bus.write_leds   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.buf",  32'(bus.uart_to_cpu_buf), 32'd0);
        check("rst.leds", 32'(bus.leds),            32'd0);
        check_status("rst");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single frame, latency and pop back to empty.
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        check_status("a5");
        pop_check("a5.pop");
        check_status("a5.empty");
        check("a5.buf0", 32'(bus.uart_to_cpu_buf), 32'd0);

        // Nine frames without pops: ninth overruns.
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
        check_status("ovr.full");
        for (int i = 0; i < 8; i++) pop_check("ovr.pop");
        check_status("ovr.drained");
        err_clear();
        check_status("ovr.clr");

        // Short low glitch is rejected at the start-bit check.
        bus.uart_in = 1'b0;
        repeat (4) @(negedge clk);
        bus.uart_in = 1'b1;
        repeat (30) @(negedge clk);
        check_status("glitch");
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        check_status("glitch.3c");
        pop_check("glitch.pop");

        // Bad stop bit, then a normal frame.
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        check_status("ferr");
        send_frame(8'h66, 1'b1, 1'b0, 1'b0);
        check_status("ferr.66");
        pop_check("ferr.pop");
        err_clear();
        check_status("ferr.clr");

        // Full FIFO with a pop on the exact stop-sample edge.
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0);
        send_frame(8'h77, 1'b1, 1'b0, 1'b1);
        check_status("popstop");
        for (int i = 0; i < 8; i++) pop_check("popstop.pop");
        check_status("popstop.drained");

        // LED register, unaffected by RX traffic.
        bus.leds_array = 8'h3C;
        bus.write_leds = 1'b1;
        @(negedge clk);
        bus.write_leds = 1'b0;
        bus.leds_array = 8'hFF;
        check("leds.write", 32'(bus.leds), 32'h3C);
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        check("leds.hold", 32'(bus.leds), 32'h3C);
        check_status("leds.81");

        // Reset in the middle of a frame discards it.
        bus.uart_in = 1'b0;
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.uart_in = 1'b1;
        @(negedge clk);
        exp_q.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        check_status("midrst.in");
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("midrst.leds", 32'(bus.leds),            32'd0);
        check("midrst.buf",  32'(bus.uart_to_cpu_buf), 32'd0);
        check_status("midrst.after");
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        pop_check("midrst.pop");
        check_status("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo_periph.md
Name: uart_rx_fifo_periph

Overview:
Parametrised UART receive peripheral feeding the MIPS core's int0 interrupt line and LED output port. A serial receiver with configurable bit timing and data width pushes completed frames into a show-ahead FIFO. A level interrupt stays asserted while the FIFO holds data, and the CPU pops one entry per read-end strobe. The block also holds the CPU-written LED register and sticky overrun and framing-error flags.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; even, at least 4.
DATA_BITS, 8, data bits per frame (5..9), LSB first, no parity, 1 stop bit.
FIFO_DEPTH, 8, receive FIFO entries; power of two, at least 2.
LED_WIDTH, 8, width of the LED register.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
uart_in  in  1  asynchronous serial RX line, idle high
read_int  out  1  interrupt to CPU; high while FIFO not empty
uart_to_cpu_buf  out  DATA_BITS  FIFO head entry (show-ahead)
cpu_end_read  in  1  one-cycle pop strobe from CPU
fifo_count  out  clog2(FIFO_DEPTH)+1  current number of FIFO entries
overrun  out  1  sticky: a frame was dropped because the FIFO was full
frame_err  out  1  sticky: a stop bit was sampled low
err_clr  in  1  clears overrun and frame_err
leds_array  in  LED_WIDTH  LED data from CPU
write_leds  in  1  LED write strobe
leds  out  LED_WIDTH  registered LED outputs

Behaviour:
- Reset (synchronous, active-high): every output is 0; FIFO is flushed; RX FSM goes to IDLE; any frame in progress is discarded.
- Input path: uart_in passes through a 2-flop synchronizer. All references to "the line" below mean the synchronized signal.
- RX FSM has four states: IDLE, START, DATA, STOP.
- IDLE: when the line is low, load the bit counter with CLKS_PER_BIT/2-1 and move to START.
- START: at counter expiry, sample the line.
  - If low, move to DATA; the counter runs CLKS_PER_BIT-1 per bit.
  - If high, treat it as a glitch and return to IDLE; nothing is recorded.
- DATA: at each counter expiry, shift the sampled bit into the MSB of the shift register (LSB-first reception). After DATA_BITS samples, move to STOP.
- STOP: at counter expiry, sample the line.
  - If high, push the byte and return to IDLE.
  - If low, set frame_err, drop the byte, and remain in STOP until the line is high; then return to IDLE. Any further falling edge therefore requires the line to have been idle first.
- Push: if the FIFO is full and there is no pop in the same cycle, drop the byte and set overrun. The FIFO contents are unchanged.
- Pop: cpu_end_read high while fifo_count>0 advances the read pointer on that edge. A pop on an empty FIFO is ignored.
- Simultaneous push and pop: both occur and fifo_count is unchanged. At full, the pop frees a slot, so the push is accepted and overrun is not set.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. fifo_count is registered and updated by +1, -1 or 0.
- uart_to_cpu_buf always shows mem[rd_ptr] when count>0 and reads 0 when empty.
- read_int = (fifo_count != 0) and is registered with the count. It rises the cycle after the push edge and falls on the edge of the pop that empties the FIFO.
- Latency: stop-bit sample edge to read_int high is 1 clk.
- Sticky flags: set and clear only per the rules below.
  - err_clr clears both overrun and frame_err.
  - A set condition in the same cycle as err_clr wins (the flag stays 1).
  - frame_err and overrun events never push data.
- LEDs: write_leds high captures leds_array into leds on that edge. leds holds its value otherwise and is unaffected by RX activity.
- Reset mid-frame: FSM returns to IDLE immediately. If the line is still low after reset, the FSM enters START; a continuously low line then causes a frame_err through the normal path.

Test Plan:
- Send frame 0xA5 (CLKS_PER_BIT=16, DATA_BITS=8) -> read_int=1 one clk after the stop sample, uart_to_cpu_buf=0xA5, fifo_count=1; pulse cpu_end_read -> read_int=0, count=0, buf=0.
- Send 9 frames 0x01..0x09 with no pops (FIFO_DEPTH=8) -> count=8, overrun=1; 8 pops return 0x01..0x08 in order; err_clr -> overrun=0.
- Hold uart_in low for 4 clks, then high -> no push, FSM back in IDLE, flags stay 0; a following valid 0x3C frame is received correctly.
- Frame 0x55 with stop bit driven low -> frame_err=1, count unchanged; release line high, then send 0x66 -> 0x66 pushed normally.
- FIFO full, cpu_end_read asserted on the exact stop-sample edge of frame 0x77 -> count stays 8, overrun=0, 0x77 is the last entry popped.
- write_leds with leds_array=0x3C -> leds=0x3C on the next edge; assert rst mid-frame -> leds=0, count=0, read_int=0, the partial frame is never pushed.
